bus_rr_arbiter: RTL and testbench
=================================

# bus_rr_arbiter

Four-requester round-robin arbiter that shares one bus/memory port between up to four masters. It drives the select of the 32-bit 4:1 datapath mux (`mux4_1`) that steers the winning requester's address/data onto the shared port, and sequences the port handshake. It holds the grant until the port accepts the transaction or a timeout expires, then acknowledges the requester and re-arbitrates.

## Interface
- `TIMEOUT`, default 16: number of GRANT cycles allowed without `bus_ready` before the transaction is aborted; 0 disables the timeout.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  4: level request per requester, index = mux input (0 = `zero` … 3 = `three`).
- `ack`  out  4: one-hot, one-cycle completion pulse to the served requester.
- `err`  out  1: one-cycle pulse, coincident with `ack`, when the transaction timed out.
- `sel`  out  2: mux select, connected to `mux4_1.sel`.
- `bus_valid`  out  1: shared port request; high for the whole GRANT state.
- `bus_ready`  in  1: shared port accepts the transaction (sampled only in GRANT).
- `busy`  out  1: high in GRANT and DONE.

## Operation
- State machine: IDLE, GRANT, DONE. Reset state: IDLE.
- IDLE: if `req != 0`, pick the winner by searching indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and take the first with `req` set; register `sel <= winner`, clear the timeout counter, go to GRANT. If `req == 0`, stay.
- GRANT: `bus_valid = 1`, `sel` stable. Requests from other requesters are ignored; the grant is not preempted.
  - `bus_ready == 1`: go to DONE with `err_q = 0`.
  - Otherwise, if `TIMEOUT != 0` and the counter equals `TIMEOUT-1`: go to DONE with `err_q = 1`. Otherwise increment the counter.
  - `bus_ready` and the timeout in the same cycle: `bus_ready` wins and `err` stays 0.
- DONE (one cycle): `ack[sel] = 1`, `err = err_q`, `bus_valid = 0`; `ptr <= sel + 1` (2-bit wrap, 3 → 0); go to IDLE.
- A requester with no further transaction deasserts `req` at the edge after it sees `ack`. A `req` still high in the following IDLE cycle is a new request.
- `sel` holds its last value in IDLE and DONE; the mux output is don't-care when `bus_valid = 0`.
- Timeout counter width is `$clog2(TIMEOUT+1)`, with a minimum of 1 bit. It saturates and never wraps.
- `ack`, `err`, `bus_valid` and `busy` are decoded from registered state only. No combinational path from `req` or `bus_ready` to any output.

## Timing
- Reset values: state IDLE, `sel = 0`, ptr 0, counter 0, `ack = 0`, `err = 0`, `bus_valid = 0`, `busy = 0`.
- Reset assertion is asynchronous from any state. All outputs go to reset values immediately, an in-flight transaction is dropped with no `ack`, and after release arbitration restarts from ptr 0.
- `req` high in IDLE in cycle 0:
  - cycle 1: GRANT, `sel` valid, `bus_valid = 1`.
  - `bus_ready` sampled high in cycle k ≥ 1: cycle k+1 is DONE with `ack`, cycle k+2 is IDLE.
- Minimum request-to-ack latency is 2 cycles. Maximum back-to-back throughput is one transaction per 3 cycles.
- Timeout: `bus_valid` stays high for exactly `TIMEOUT` cycles, then DONE with `err = 1`.
- `req` changes during GRANT or DONE have no effect until the next IDLE cycle.

## Test plan
- Reset: hold `rst_n = 0` with random `req`/`bus_ready` → `sel = 0`, `ack = 0`, `err = 0`, `bus_valid = 0`, `busy = 0`. Then assert `rst_n = 0` mid-GRANT → `bus_valid` drops the same cycle, no `ack`; with `req = 4'b1111` after release the first grant goes to 0.
- Single request: `req = 4'b0100`, `bus_ready = 1` → cycle 1 `sel = 2`, `bus_valid = 1`; cycle 2 `ack = 4'b0100`, `err = 0`; cycle 3 IDLE.
- Fairness: `req = 4'b1111` held, `bus_ready = 1` → grants 0, 1, 2, 3, 0 at 3-cycle spacing, each `ack` matching the granted index.
- Pointer skip: after a grant to 1, `req = 4'b1010` → next grant 3, then 1.
- Wait states: `req[0]`, `bus_ready` low for 5 cycles then high, `TIMEOUT = 16` → `bus_valid` high 6 cycles, `ack = 4'b0001`, `err = 0`.
- Timeout: `TIMEOUT = 4`, `bus_ready` stuck low → `bus_valid` high exactly 4 cycles, then `ack` and `err` pulse together. Repeat with `bus_ready = 1` on the 4th cycle → `err = 0`.

Source files
------------

// File: rtl/bus_rr_arbiter_if.sv
// Shared-port arbitration bundle: requester levels, completion pulses,
// datapath mux select and the shared port handshake.
//
// Handshake: the arbiter raises bus_valid for the whole time a grant is
// held; the port raises bus_ready in a cycle where it takes the transaction.
// A transfer completes on the rising edge where bus_valid && bus_ready are
// both high. bus_ready is ignored while bus_valid is low, and bus_valid
// never drops before that edge unless the grant times out.
interface bus_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] ack;
    logic       err;
    logic [1:0] sel;
    logic       bus_valid;
    logic       bus_ready;
    logic       busy;

    // Arbiter side.
    modport slave (
        input  req,
        input  bus_ready,
        output ack,
        output err,
        output sel,
        output bus_valid,
        output busy
    );

    // Requesters plus the shared port.
    modport master (
        output req,
        output bus_ready,
        input  ack,
        input  err,
        input  sel,
        input  bus_valid,
        input  busy
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Four-requester round-robin arbiter for one shared bus/memory port.
// Holds the grant until the port accepts or the timeout expires, then pulses
// ack (and err on timeout) for one cycle and re-arbitrates from the
// requester after the one just served.
module bus_rr_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_rr_arbiter_if.slave  bus,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter just wide enough to hold TIMEOUT; one bit when timeout is off.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr, ptr_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          err_q, err_d;

    logic [1:0]    winner;
    logic          found;
    logic [1:0]    idx;

    // Round-robin search starting at ptr: first requester found wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state logic for the grant sequence, counter and pointer.
    always_comb begin
        state_d = state;
        sel_d   = sel_q;
        ptr_d   = ptr;
        cnt_d   = cnt;
        err_d   = err_q;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_d   = winner;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Acceptance beats a timeout landing in the same cycle.
                if (bus.bus_ready) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                ptr_d   = sel_q + 2'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= '0;
            ptr   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            sel_q <= sel_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
            err_q <= err_d;
        end
    end

    // Outputs decode registered state only; no path from req or bus_ready.
    assign bus.bus_valid = (state == GRANT);
    assign bus.busy      = (state != IDLE);
    assign bus.ack       = (state == DONE) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.err       = (state == DONE) && err_q;
    assign bus.sel       = sel_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: two instances (TIMEOUT 16 and 4) share the same
// stimulus; a transaction-level model predicts each one, a scoreboard queue
// holds expected completions and a monitor checks outputs every cycle.
module tb_bus_rr_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_rr_arbiter_if bus_a ();
    bus_rr_arbiter_if bus_b ();
    logic [1:0] dbg_a, dbg_b;

    bus_rr_arbiter #(.TIMEOUT(16)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_a.slave),
        .state_dbg (dbg_a)
    );

    bus_rr_arbiter #(.TIMEOUT(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_b.slave),
        .state_dbg (dbg_b)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // phase: 0 waiting for requests, 1 port held, 2 completion cycle
    int m_phase [2];
    int m_ptr   [2];
    int m_sel   [2];
    int m_wait  [2];
    bit m_err   [2];
    int m_to    [2] = '{16, 4};

    logic [2:0] exp_q0[$];
    logic [2:0] exp_q1[$];

    bit mon_en = 1'b0;
    bit log_en = 1'b0;
    int grant_log[$];

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", name, inst, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0;
            m_ptr[i]   = 0;
            m_sel[i]   = 0;
            m_wait[i]  = 0;
            m_err[i]   = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic finish_txn(input int i, input bit e);
        logic [2:0] item;
        m_phase[i] = 2;
        m_err[i]   = e;
        item = {e, 2'(m_sel[i])};
        if (i == 0) exp_q0.push_back(item);
        else        exp_q1.push_back(item);
    endtask

    // Advance each model by one clock given the inputs seen at that edge.
    task automatic model_step(input logic [3:0] r, input logic rdy);
        int win;
        for (int i = 0; i < 2; i++) begin
            case (m_phase[i])
                0: begin
                    win = -1;
                    for (int k = 0; k < 4; k++) begin
                        if (win < 0 && r[(m_ptr[i] + k) % 4]) win = (m_ptr[i] + k) % 4;
                    end
                    if (win >= 0) begin
                        m_sel[i]   = win;
                        m_wait[i]  = 0;
                        m_phase[i] = 1;
                    end
                end
                1: begin
                    if (rdy) finish_txn(i, 1'b0);
                    else if (m_to[i] != 0 && m_wait[i] + 1 == m_to[i]) finish_txn(i, 1'b1);
                    else m_wait[i]++;
                end
                default: begin
                    m_ptr[i]   = (m_sel[i] + 1) % 4;
                    m_phase[i] = 0;
                end
            endcase
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic rst_v, input logic [3:0] r, input logic rdy);
        @(negedge clk);
        rst_n           = rst_v;
        bus_a.req       = r;
        bus_b.req       = r;
        bus_a.bus_ready = rdy;
        bus_b.bus_ready = rdy;
        if (!rst_v) model_reset();
        else        model_step(r, rdy);
    endtask

    task automatic drive_n(input int n, input logic [3:0] r, input logic rdy);
        for (int j = 0; j < n; j++) drive_cycle(1'b1, r, rdy);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon_inst(input int i, input logic [3:0] ack, input logic err,
                            input logic [1:0] sel, input logic bv, input logic busy);
        logic [3:0] e_ack;
        logic [2:0] item;
        int         a_idx;
        e_ack = (m_phase[i] == 2) ? (4'b0001 << m_sel[i]) : 4'b0000;
        check("bus_valid", i, 32'(bv),   32'(m_phase[i] == 1));
        check("busy",      i, 32'(busy), 32'(m_phase[i] != 0));
        check("sel",       i, 32'(sel),  32'(m_sel[i]));
        check("ack",       i, 32'(ack),  32'(e_ack));
        check("err",       i, 32'(err),  32'(m_phase[i] == 2 && m_err[i]));
        if (ack != 4'b0000) begin
            a_idx = -1;
            for (int k = 0; k < 4; k++) if (ack[k]) a_idx = k;
            if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected inst%0d got ack=%0h want none t=%0t", i, ack, $time);
            end else begin
                item = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check("sb_ack", i, 32'(ack), 32'(4'b0001 << item[1:0]));
                check("sb_err", i, 32'(err), 32'(item[2]));
            end
            if (i == 0 && log_en) grant_log.push_back(a_idx);
        end
    endtask

    // Sample outputs 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                mon_inst(0, bus_a.ack, bus_a.err, bus_a.sel, bus_a.bus_valid, bus_a.busy);
                mon_inst(1, bus_b.ack, bus_b.err, bus_b.sel, bus_b.bus_valid, bus_b.busy);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        logic       rdy;

        rst_n           = 1'b0;
        bus_a.req       = 4'b0000;
        bus_b.req       = 4'b0000;
        bus_a.bus_ready = 1'b0;
        bus_b.bus_ready = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Reset held with random inputs.
        for (int j = 0; j < 4; j++)
            drive_cycle(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        // Single request.
        drive_n(3, 4'b0100, 1'b1);
        drive_n(3, 4'b0000, 1'b0);

        // Pointer skip: grant 1, then 3, then 1.
        drive_n(3, 4'b0010, 1'b1);
        drive_n(6, 4'b1010, 1'b1);
        drive_n(3, 4'b0000, 1'b0);

        // Wait states: five not-ready grant cycles then acceptance.
        drive_n(6, 4'b0001, 1'b0);
        drive_n(1, 4'b0001, 1'b1);
        drive_n(6, 4'b0000, 1'b0);

        // Port stuck not-ready.
        drive_n(20, 4'b0001, 1'b0);
        drive_n(25, 4'b0000, 1'b0);

        // Acceptance on the last permitted grant cycle of the short timeout.
        drive_n(1, 4'b0001, 1'b0);
        drive_n(3, 4'b0000, 1'b0);
        drive_n(1, 4'b0000, 1'b1);
        drive_n(20, 4'b0000, 1'b0);

        // Asynchronous reset in the middle of a grant.
        drive_n(2, 4'b1111, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_bus_valid", 0, 32'(bus_a.bus_valid), 32'd0);
        check("rst_bus_valid", 1, 32'(bus_b.bus_valid), 32'd0);
        check("rst_busy",      0, 32'(bus_a.busy),      32'd0);
        check("rst_ack",       1, 32'(bus_b.ack),       32'd0);
        model_reset();
        drive_cycle(1'b0, 4'b1111, 1'b1);
        drive_cycle(1'b0, 4'b1111, 1'b1);

        // Fairness from ptr 0 after reset release.
        log_en = 1'b1;
        drive_n(15, 4'b1111, 1'b1);
        log_en = 1'b0;
        drive_n(6, 4'b0000, 1'b0);
        check("fair_count", 0, 32'(grant_log.size()), 32'd5);
        for (int j = 0; j < 5; j++)
            if (j < grant_log.size()) check("fair_order", j, 32'(grant_log[j]), 32'(exp_order[j]));

        // Randomized traffic with occasional stuck-low port stretches.
        for (int j = 0; j < 1500; j++) begin
            r   = 4'($urandom_range(0, 15));
            rdy = ((j % 200) < 25) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
            drive_cycle(1'b1, r, rdy);
        end

        // Drain and confirm every predicted completion was seen.
        drive_n(25, 4'b0000, 1'b0);
        check("sb_drain", 0, 32'(exp_q0.size()), 32'd0);
        check("sb_drain", 1, 32'(exp_q1.size()), 32'd0);
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
